// File: rtl/game_timer.sv
// Play-time counter for the end-of-game screen: counts {minutes, seconds} from start to game_over.
// All outputs are registered; the prescaler divides pclk down to one tick per second.
module game_timer #(
    parameter int CLK_FREQ = 65_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        clear,
    output logic [11:0] game_time,
    output logic        running,
    output logic        endgame_en,
    output logic        sec_tick,
    output logic        saturated
);

    localparam int          PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);
    localparam logic [5:0]  MAXM = 6'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic [5:0]    r_min, w_min_nx;
    logic [5:0]    r_sec, w_sec_nx;
    logic          r_run, w_run_nx;
    logic          r_end, w_end_nx;
    logic          r_tick, w_tick_nx;
    logic          r_sat, w_sat_nx;

    logic          w_last;

    assign w_last = (r_presc == TC);

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_min_nx   = r_min;
        w_sec_nx   = r_sec;
        w_run_nx   = r_run;
        w_end_nx   = r_end;
        w_tick_nx  = 1'b0;
        w_sat_nx   = r_sat;

        if (clear) begin
            w_state_nx = S_IDLE;
            w_presc_nx = '0;
            w_min_nx   = '0;
            w_sec_nx   = '0;
            w_run_nx   = 1'b0;
            w_end_nx   = 1'b0;
            w_sat_nx   = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!pause) begin
                        w_presc_nx = w_last ? '0 : r_presc + PW'(1);
                        // Once saturated the time freezes; the prescaler may keep spinning harmlessly.
                        if (w_last && !r_sat) begin
                            w_tick_nx = 1'b1;
                            if (r_sec == 6'd59) begin
                                w_sec_nx = '0;
                                w_min_nx = r_min + 6'd1;
                            end else begin
                                w_sec_nx = r_sec + 6'd1;
                            end
                            if (r_min == MAXM && r_sec == 6'd58)
                                w_sat_nx = 1'b1;
                        end
                    end
                    if (game_over) begin
                        w_state_nx = S_FIN;
                        w_run_nx   = 1'b0;
                        w_end_nx   = 1'b1;
                    end
                end
                S_IDLE, S_FIN: begin
                    if (start) begin
                        w_state_nx = S_RUN;
                        w_presc_nx = '0;
                        w_min_nx   = '0;
                        w_sec_nx   = '0;
                        w_run_nx   = 1'b1;
                        w_end_nx   = 1'b0;
                        w_sat_nx   = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_presc_nx = '0;
                    w_min_nx   = '0;
                    w_sec_nx   = '0;
                    w_run_nx   = 1'b0;
                    w_end_nx   = 1'b0;
                    w_sat_nx   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_run   <= 1'b0;
            r_end   <= 1'b0;
            r_tick  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_min   <= w_min_nx;
            r_sec   <= w_sec_nx;
            r_run   <= w_run_nx;
            r_end   <= w_end_nx;
            r_tick  <= w_tick_nx;
            r_sat   <= w_sat_nx;
        end
    end

    assign game_time  = {r_min, r_sec};
    assign running    = r_run;
    assign endgame_en = r_end;
    assign sec_tick   = r_tick;
    assign saturated  = r_sat;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with CLK_FREQ=4, MAX_MIN=1.
module tb_game_timer;

    logic        pclk = 1'b0;
    logic        rst, start, pause, game_over, clear;
    logic [11:0] game_time;
    logic        running, endgame_en, sec_tick, saturated;

    int n_chk  = 0;
    int n_fail = 0;

    game_timer #(.CLK_FREQ(4), .MAX_MIN(1)) dut (
        .pclk(pclk), .rst(rst), .start(start), .pause(pause),
        .game_over(game_over), .clear(clear), .game_time(game_time),
        .running(running), .endgame_en(endgame_en), .sec_tick(sec_tick),
        .saturated(saturated)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          n;
        logic        st, pa, go, cl;
        logic [11:0] e_time;
        logic        e_run, e_end, e_tick, e_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_n(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            clk1();
            if (sec_tick) ticks++;
        end
    endtask

    task automatic chk_all(input string name, input logic [11:0] t, input logic r,
                           input logic e, input logic k, input logic s);
        chk({name, "_time"}, 32'(game_time), 32'(t));
        chk({name, "_running"}, 32'(running), 32'(r));
        chk({name, "_endgame"}, 32'(endgame_en), 32'(e));
        chk({name, "_tick"}, 32'(sec_tick), 32'(k));
        chk({name, "_sat"}, 32'(saturated), 32'(s));
    endtask

    initial begin
        int ticks;
        rst = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; clear = 1'b0;

        //                n  st pa go cl  time     run end tck sat
        vecs[0]  = '{1,  0, 0, 0, 1, 12'h000, 0, 0, 0, 0};  // clear from saturated RUNNING
        vecs[1]  = '{1,  0, 0, 1, 0, 12'h000, 0, 0, 0, 0};  // game_over ignored in IDLE
        vecs[2]  = '{1,  1, 0, 0, 0, 12'h000, 1, 0, 0, 0};
        vecs[3]  = '{31, 0, 0, 0, 0, 12'h007, 1, 0, 0, 0};  // 00:07, prescaler at 3
        vecs[4]  = '{1,  0, 0, 1, 0, 12'h008, 0, 1, 1, 0};  // final second counted
        vecs[5]  = '{8,  0, 0, 0, 0, 12'h008, 0, 1, 0, 0};
        vecs[6]  = '{1,  0, 0, 1, 0, 12'h008, 0, 1, 0, 0};
        vecs[7]  = '{1,  0, 1, 0, 0, 12'h008, 0, 1, 0, 0};
        vecs[8]  = '{1,  1, 0, 0, 0, 12'h000, 1, 0, 0, 0};  // FINISHED -> RUNNING
        vecs[9]  = '{1,  1, 0, 0, 1, 12'h000, 0, 0, 0, 0};  // clear beats start
        vecs[10] = '{1,  1, 0, 0, 0, 12'h000, 1, 0, 0, 0};
        vecs[11] = '{1,  1, 0, 1, 0, 12'h000, 0, 1, 0, 0};  // game_over beats start
        vecs[12] = '{1,  0, 0, 1, 1, 12'h000, 0, 0, 0, 0};  // clear beats game_over

        repeat (2) clk1();
        chk_all("reset", 12'h000, 0, 0, 0, 0);
        rst = 1'b0;
        clk1();
        chk_all("idle", 12'h000, 0, 0, 0, 0);

        // --- basic counting: 20 cycles -> 00:05, tick every 4th cycle
        start = 1'b1; clk1(); start = 1'b0;
        chk_all("start", 12'h000, 1, 0, 0, 0);
        ticks = 0;
        for (int i = 1; i <= 20; i++) begin
            clk1();
            chk($sformatf("tick_c%0d", i), 32'(sec_tick), 32'((i % 4) == 0));
            if (sec_tick) ticks++;
        end
        chk("time_0005", 32'(game_time), 32'h005);
        chk("ticks_5", 32'(ticks), 32'd5);

        // --- minute rollover
        run_n(216, ticks);
        chk("time_0059", 32'(game_time), 32'h03B);
        run_n(4, ticks);
        chk("time_0100", 32'(game_time), 32'h040);
        chk("ticks_rollover", 32'(ticks), 32'd1);

        // --- pause at prescaler=2
        run_n(2, ticks);
        pause = 1'b1;
        run_n(10, ticks);
        chk("pause_time", 32'(game_time), 32'h040);
        chk("pause_ticks", 32'(ticks), 32'd0);
        chk("pause_running", 32'(running), 32'd1);
        pause = 1'b0;
        clk1();
        chk("resume_c1_tick", 32'(sec_tick), 32'd0);
        clk1();
        chk("resume_c2_tick", 32'(sec_tick), 32'd1);
        chk("resume_time", 32'(game_time), 32'h041);

        // --- saturation at 01:59
        run_n(231, ticks);
        chk("pre_sat_time", 32'(game_time), 32'h07A);
        chk("pre_sat_flag", 32'(saturated), 32'd0);
        chk("pre_sat_ticks", 32'(ticks), 32'd57);
        clk1();
        chk_all("sat_edge", 12'h07B, 1, 0, 1, 1);
        run_n(20, ticks);
        chk("post_sat_ticks", 32'(ticks), 32'd0);
        chk_all("post_sat", 12'h07B, 1, 0, 0, 1);

        // --- table-driven sequences
        foreach (vecs[v]) begin
            start = vecs[v].st; pause = vecs[v].pa;
            game_over = vecs[v].go; clear = vecs[v].cl;
            for (int c = 0; c < vecs[v].n; c++) begin
                clk1();
                start = 1'b0; game_over = 1'b0; clear = 1'b0;
            end
            pause = 1'b0;
            chk_all($sformatf("vec%0d", v), vecs[v].e_time, vecs[v].e_run,
                    vecs[v].e_end, vecs[v].e_tick, vecs[v].e_sat);
        end

        // --- asynchronous reset mid-count at 00:03
        start = 1'b1; clk1(); start = 1'b0;
        run_n(12, ticks);
        chk("pre_rst_time", 32'(game_time), 32'h003);
        chk("pre_rst_running", 32'(running), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 12'h000, 0, 0, 0, 0);
        #2 rst = 1'b0;
        clk1();
        chk_all("after_rst", 12'h000, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
